video_source_mux: RTL and testbench

//  Frame-synchronous N-way video source selector between the pixel sources (VGA capture, static image,

---
 rtl/video_source_mux.sv | 105 ++++++++++
 tb/tb_video_source_mux.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/video_source_mux.sv
// video_source_mux: frame-synchronous N-way pixel source selector with start handshake, pixel count and stall stats.
// Optional: define VSRC_MUX_PATTERN_EN to add an internal ramp source selected by sel == NUM_SRC.
module video_source_mux #(
    parameter int NUM_SRC = 3,
    parameter int SEL_W   = 2,
    parameter int PIXEL_W = 8,
    parameter int N_PIXEL = 480000,
    parameter int CNT_W   = 19
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       start,
    output logic                       start_ack,
    output logic [NUM_SRC-1:0]         src_start,
    input  logic [NUM_SRC-1:0]         src_start_ack,
    input  logic [NUM_SRC*PIXEL_W-1:0] src_pixel,
    input  logic [NUM_SRC-1:0]         src_valid,
    output logic [NUM_SRC-1:0]         src_ready,
    output logic [PIXEL_W-1:0]         pixel,
    output logic                       valid,
    input  logic                       ready,
    output logic [SEL_W-1:0]           active_src,
    output logic                       frame_done,
    output logic [15:0]                stall_cnt
);
    typedef enum logic [1:0] {IDLE, REQ, STREAM, DRAIN} state_t;
    localparam logic [SEL_W-1:0] RAMP_ID  = SEL_W'(NUM_SRC);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_PIXEL - 1);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] sel_cl;
    logic [PIXEL_W-1:0] mux_pixel;
    logic is_ramp, mux_ack, mux_valid, rdy, accept, drained;
`ifdef VSRC_MUX_PATTERN_EN
    assign is_ramp = active_src == RAMP_ID;
    assign sel_cl  = sel > RAMP_ID ? '0 : sel;
`else
    assign is_ramp = 1'b0;
    assign sel_cl  = sel >= RAMP_ID ? '0 : sel;
`endif
    assign rdy     = state == STREAM && (!valid || ready);
    assign accept  = rdy && mux_valid;
    assign drained = !valid || ready;
    // The ramp source, when present, is always valid and acknowledges its own start.
    always_comb begin
        mux_ack   = is_ramp;
        mux_valid = is_ramp;
        mux_pixel = is_ramp ? cnt[PIXEL_W-1:0] : '0;
        src_start = '0;
        src_ready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (active_src == SEL_W'(i)) begin
                mux_ack      = src_start_ack[i];
                mux_valid    = src_valid[i];
                mux_pixel    = src_pixel[i*PIXEL_W +: PIXEL_W];
                src_start[i] = state == REQ;
                src_ready[i] = rdy;
            end
        end
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? REQ : IDLE;
            REQ:     state_nx = mux_ack ? STREAM : REQ;
            STREAM:  state_nx = accept && cnt == LAST_CNT ? DRAIN : STREAM;
            default: state_nx = drained ? IDLE : DRAIN;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            start_ack  <= 1'b0;
            frame_done <= 1'b0;
            pixel      <= '0;
            valid      <= 1'b0;
            active_src <= '0;
            stall_cnt  <= '0;
            cnt        <= '0;
        end else begin
            start_ack  <= state == REQ && mux_ack;
            frame_done <= state == DRAIN && drained;
            if (state == IDLE && start) begin
                active_src <= sel_cl;
                stall_cnt  <= '0;
            end
            if (state == REQ && mux_ack)
                cnt <= '0;
            if (accept) begin
                pixel <= mux_pixel;
                valid <= 1'b1;
                cnt   <= cnt + CNT_W'(1);
            end else if (valid && ready)
                valid <= 1'b0;
            if (state == STREAM && mux_valid && !rdy && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_video_source_mux.sv
// tb_video_source_mux: directed frames with randomized valid/ready against a transaction-level model.
module tb_video_source_mux;
    localparam int NS = 3, PW = 8, NP = 16;
    logic clock = 1'b0, reset = 1'b1;
    logic [1:0] sel = '0;
    logic start = 1'b0, ready = 1'b0;
    logic [2:0] src_start_ack = '0, src_valid = '0;
    logic [NS*PW-1:0] src_pixel = '0;
    logic start_ack, valid, frame_done;
    logic [2:0] src_start, src_ready;
    logic [7:0] pixel;
    logic [1:0] active_src;
    logic [15:0] stall_cnt;
    int checks = 0, errors = 0;
    int idx [NS];
    logic [7:0] got [$];

    video_source_mux #(.NUM_SRC(NS), .SEL_W(2), .PIXEL_W(PW), .N_PIXEL(NP), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .sel(sel), .start(start), .start_ack(start_ack),
        .src_start(src_start), .src_start_ack(src_start_ack), .src_pixel(src_pixel),
        .src_valid(src_valid), .src_ready(src_ready), .pixel(pixel), .valid(valid), .ready(ready),
        .active_src(active_src), .frame_done(frame_done), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Source i emits base(i)+0, base(i)+1, ... advancing only on its own handshake.
    function automatic logic [7:0] base(input int e);
        return e == 0 ? 8'd100 : e == 1 ? 8'd50 : 8'd0;
    endfunction

    task automatic drive_pix();
        for (int i = 0; i < NS; i++) src_pixel[i*PW +: PW] = base(i) + 8'(idx[i]);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_start_ack"}, start_ack, 0);
        chk({tag, "_src_start"}, src_start, 0);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_pixel"}, pixel, 0);
        chk({tag, "_valid"}, valid, 0);
        chk({tag, "_active_src"}, active_src, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_stall_cnt"}, stall_cnt, 0);
    endtask

    task automatic run_frame(input int s, input int e, input int dly, input int pv, input int pr,
                             input bit pat, input int sel_mid, input int abort);
        bit ramp, m_stream, m_occ, m_rdy, m_acc, act_v, ohs, done;
        logic [2:0] shs;
        logic [7:0] opix;
        logic [3:0] rpat;
        logic [15:0] m_stall;
        int m_n;
        ramp = e == NS;
        rpat = 4'b1001;
        if (!ramp) idx[e] = 0;
        drive_pix();
        sel = 2'(s);
        start = 1'b1;
        @(posedge clock); #1;
        chk("active_src", active_src, 32'(e));
        chk("stall_clear", stall_cnt, 0);
        if (ramp) begin
            chk("ramp_src_start", src_start, 0);
            @(posedge clock); #1;
        end else begin
            for (int d = 0; d < dly; d++) begin
                sel = 2'($urandom);
                src_start_ack[e] = d == dly - 1;
                #1;
                chk("src_start", src_start, 1 << e);
                @(posedge clock); #1;
            end
            src_start_ack = '0;
        end
        start = 1'b0;
        chk("start_ack", start_ack, 1);
        m_stream = 1; m_occ = 0; m_n = 0; m_stall = 0; done = 0;
        got.delete();
        for (int c = 0; c < 2000 && !done; c++) begin
            src_valid = 3'($urandom);
            if (!ramp) src_valid[e] = pat || $urandom_range(99) < pv;
            ready = pat ? rpat[c % 4] : $urandom_range(99) < pr;
            if (c == 3 && sel_mid >= 0) sel = 2'(sel_mid);
            #1;
            act_v = ramp || src_valid[e];
            m_rdy = m_stream && (!m_occ || ready);
            chk("src_ready", src_ready, (m_rdy && !ramp) ? 1 << e : 0);
            if (m_stream && act_v && !m_rdy && m_stall != 16'hFFFF) m_stall++;
            m_acc = m_rdy && act_v;
            m_n += int'(m_acc);
            if (m_n == NP) m_stream = 0;
            m_occ = m_acc || (m_occ && !ready);
            shs = src_valid & src_ready;
            ohs = valid && ready;
            opix = pixel;
            @(posedge clock); #1;
            for (int i = 0; i < NS; i++) if (shs[i]) idx[i]++;
            drive_pix();
            if (ohs) got.push_back(opix);
            done = ohs && got.size() == NP;
            chk("frame_done", frame_done, 32'(done));
            if (c == 0) chk("start_ack_pulse", start_ack, 0);
            if (abort > 0 && m_n >= abort) break;
        end
        chk("active_src_hold", active_src, 32'(e));
        if (abort == 0) begin
            chk("frame_seen", 32'(done), 1);
            chk("pixel_count", got.size(), NP);
            for (int k = 0; k < got.size() && k < NP; k++) chk("pixel", got[k], base(e) + 8'(k));
            chk("stall_cnt", stall_cnt, m_stall);
            src_valid = '0;
            ready = 1'b0;
            repeat (2) @(posedge clock);
            #1;
            chk("stall_hold", stall_cnt, m_stall);
            chk("valid_idle", valid, 0);
        end
    endtask

    initial begin
        for (int i = 0; i < NS; i++) idx[i] = 0;
        drive_pix();
        repeat (2) @(posedge clock);
        #1;
        check_zero("reset");
        reset = 1'b0;
        run_frame(1, 1, 3, 70, 70, 0, -1, 0);
        run_frame(2, 2, 1, 100, 100, 0, -1, 0);
        run_frame(0, 0, 2, 100, 0, 1, -1, 0);
        chk("stall_pattern", stall_cnt, 16);
        run_frame(0, 0, 2, 80, 80, 0, 2, 7);
        reset = 1'b1;
        @(posedge clock); #1;
        check_zero("midreset");
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            src_valid = 3'($urandom);
            ready = 1'($urandom);
            @(posedge clock); #1;
            chk("no_frame_done", frame_done, 0);
        end
`ifdef VSRC_MUX_PATTERN_EN
        run_frame(3, 3, 1, 100, 60, 0, -1, 0);
`else
        run_frame(3, 0, 2, 60, 60, 0, -1, 0);
`endif
        for (int r = 0; r < 3; r++) begin
            int s;
            s = $urandom_range(NS - 1);
            run_frame(s, s, $urandom_range(4, 1), 60, 60, 0, -1, 0);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
